// File: rtl/ifmap_row_loader.sv
// ifmap_row_loader
//   Feeds one ifmap row from the global buffer into the PE's ifmap scratchpad.
//   The scratchpad is treated as a circular buffer. The loader tells the PE
//   controller when FILTER_SIZE elements (a full sliding window) are resident.
//   Each window release frees STRIDE entries, so the next elements can stream
//   in while the PE is still computing.
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   start           : begin loading a row (only honoured while idle)
//   in_valid/in_data/in_ready : upstream element stream (valid/ready)
//   ifmap_wen/ifmap_w_addr/ifmap_din : scratchpad write port (same-edge write)
//   win_release     : PE controller finished the current window
//   win_valid       : a full window is resident, starting at win_base
//   busy            : a row is in progress
//   done            : one-cycle pulse after the last window of the row is released
//   release_err     : sticky flag, a release arrived with no window resident
module ifmap_row_loader #(
  parameter int WIDTH            = 4,
  parameter int SIZE_IFMAP       = 4,
  parameter int ADDR_WIDTH_IFMAP = $clog2(SIZE_IFMAP),
  parameter int FILTER_SIZE      = 3,
  parameter int STRIDE           = 1,
  parameter int ROW_LEN          = 6,
  parameter int NUM_WIN          = (ROW_LEN - FILTER_SIZE) / STRIDE + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        in_ready,
  output logic                        ifmap_wen,
  output logic [ADDR_WIDTH_IFMAP-1:0] ifmap_w_addr,
  output logic [WIDTH-1:0]            ifmap_din,
  input  logic                        win_release,
  output logic                        win_valid,
  output logic [ADDR_WIDTH_IFMAP-1:0] win_base,
  output logic                        busy,
  output logic                        done,
  output logic                        release_err
);

  localparam int AW     = ADDR_WIDTH_IFMAP;
  localparam int CW     = ADDR_WIDTH_IFMAP + 1;   // count reaches SIZE_IFMAP
  localparam int IN_CW  = $clog2(ROW_LEN + 1);
  localparam int WIN_CW = $clog2(NUM_WIN + 1);

  localparam logic [AW-1:0]     LAST_ADDR = AW'(SIZE_IFMAP - 1);
  localparam logic [CW-1:0]     SIZE_C    = CW'(SIZE_IFMAP);
  localparam logic [CW-1:0]     FILTER_C  = CW'(FILTER_SIZE);
  localparam logic [CW-1:0]     STRIDE_C  = CW'(STRIDE);
  localparam logic [IN_CW-1:0]  LAST_IN   = IN_CW'(ROW_LEN - 1);
  localparam logic [WIN_CW-1:0] NUM_WIN_C = WIN_CW'(NUM_WIN);
  localparam logic [WIN_CW-1:0] LAST_WIN  = WIN_CW'(NUM_WIN - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t              state_reg, state_next;
  logic [AW-1:0]       wptr_reg, wptr_next;
  logic [AW-1:0]       rptr_reg, rptr_next;
  logic [CW-1:0]       count_reg, count_next;
  logic [IN_CW-1:0]    in_cnt_reg, in_cnt_next;
  logic [WIN_CW-1:0]   win_cnt_reg, win_cnt_next;
  logic                release_err_reg;
  logic                done_reg;

  logic                accept;
  logic                rel;
  logic                window_ok;
  logic [CW-1:0]       rptr_sum;
  logic [CW-1:0]       rptr_wrapped;

  // Window availability depends on registered state only.
  assign window_ok = (count_reg >= FILTER_C) && (win_cnt_reg < NUM_WIN_C);

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (accept && (in_cnt_reg == LAST_IN)) state_next = DRAIN;
      DRAIN:   if (rel && (win_cnt_reg == LAST_WIN)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  // in_ready looks only at the registered count, so a release in the same
  // cycle cannot open the input; the freed slot becomes usable next cycle.
  always_comb begin
    in_ready  = 1'b0;
    win_valid = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      LOAD: begin
        busy      = 1'b1;
        in_ready  = (count_reg < SIZE_C);
        win_valid = window_ok;
      end
      DRAIN: begin
        busy      = 1'b1;
        win_valid = window_ok;
      end
      default: ;
    endcase
  end

  assign accept       = in_valid && in_ready;
  assign rel          = win_release && win_valid;

  assign ifmap_wen    = accept;
  assign ifmap_w_addr = wptr_reg;
  assign ifmap_din    = in_data;
  assign win_base     = rptr_reg;
  assign done         = done_reg;
  assign release_err  = release_err_reg;

  // ---------------------------------------------------------------- datapath next values
  // rptr + STRIDE never exceeds 2*SIZE_IFMAP-2, so one conditional subtract
  // wraps correctly for depths that are not a power of two.
  always_comb begin
    rptr_sum     = {1'b0, rptr_reg} + STRIDE_C;
    rptr_wrapped = (rptr_sum >= SIZE_C) ? (rptr_sum - SIZE_C) : rptr_sum;

    wptr_next    = wptr_reg;
    rptr_next    = rptr_reg;
    in_cnt_next  = in_cnt_reg;
    win_cnt_next = win_cnt_reg;

    if (accept) begin
      wptr_next   = (wptr_reg == LAST_ADDR) ? '0 : (wptr_reg + AW'(1));
      in_cnt_next = in_cnt_reg + IN_CW'(1);
    end
    if (rel) begin
      rptr_next    = rptr_wrapped[AW-1:0];
      win_cnt_next = win_cnt_reg + WIN_CW'(1);
    end

    // Accept and release in the same cycle are both applied.
    count_next = count_reg + {{(CW-1){1'b0}}, accept} - (rel ? STRIDE_C : '0);
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg        <= '0;
      rptr_reg        <= '0;
      count_reg       <= '0;
      in_cnt_reg      <= '0;
      win_cnt_reg     <= '0;
      release_err_reg <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      if ((state_reg == IDLE) && start) begin
        wptr_reg    <= '0;
        rptr_reg    <= '0;
        count_reg   <= '0;
        in_cnt_reg  <= '0;
        win_cnt_reg <= '0;
      end else begin
        wptr_reg    <= wptr_next;
        rptr_reg    <= rptr_next;
        count_reg   <= count_next;
        in_cnt_reg  <= in_cnt_next;
        win_cnt_reg <= win_cnt_next;
      end
      // A release without a resident window changes nothing but this flag.
      if (win_release && !win_valid) begin
        release_err_reg <= 1'b1;
      end
      done_reg <= (state_reg == DRAIN) && rel && (win_cnt_reg == LAST_WIN);
    end
  end

endmodule

// File: tb/tb_ifmap_row_loader.sv
// Bench for ifmap_row_loader. Two instances run side by side:
//   dut0: FILTER_SIZE=3, STRIDE=1, ROW_LEN=6 (4 windows)
//   dut1: FILTER_SIZE=4, STRIDE=2, ROW_LEN=8 (3 windows, base wraps)
// Both use SIZE_IFMAP=4 and WIDTH=4, so their ports share widths.
// The reference model tracks a row in terms of elements accepted and
// windows released; occupancy, addresses and bases follow from arithmetic.
module tb_ifmap_row_loader;

  localparam int SZ = 4;
  localparam int FS [2] = '{3, 4};
  localparam int ST [2] = '{1, 2};
  localparam int RL [2] = '{6, 8};
  localparam int NW [2] = '{4, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [2];
  logic       start [2];
  logic       in_valid [2];
  logic [3:0] in_data [2];
  logic       win_release [2];
  logic       in_ready [2];
  logic       ifmap_wen [2];
  logic [1:0] ifmap_w_addr [2];
  logic [3:0] ifmap_din [2];
  logic       win_valid [2];
  logic [1:0] win_base [2];
  logic       busy [2];
  logic       done [2];
  logic       release_err [2];

  ifmap_row_loader #(.WIDTH(4), .SIZE_IFMAP(4), .FILTER_SIZE(3), .STRIDE(1), .ROW_LEN(6)) u_dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .ifmap_wen(ifmap_wen[0]), .ifmap_w_addr(ifmap_w_addr[0]),
    .ifmap_din(ifmap_din[0]), .win_release(win_release[0]), .win_valid(win_valid[0]),
    .win_base(win_base[0]), .busy(busy[0]), .done(done[0]), .release_err(release_err[0])
  );

  ifmap_row_loader #(.WIDTH(4), .SIZE_IFMAP(4), .FILTER_SIZE(4), .STRIDE(2), .ROW_LEN(8)) u_dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .ifmap_wen(ifmap_wen[1]), .ifmap_w_addr(ifmap_w_addr[1]),
    .ifmap_din(ifmap_din[1]), .win_release(win_release[1]), .win_valid(win_valid[1]),
    .win_base(win_base[1]), .busy(busy[1]), .done(done[1]), .release_err(release_err[1])
  );

  int total = 0;
  int bad = 0;
  int tmo = 0;
  int tmo_seen = 0;
  int cyc = 0;
  int armed = 0;

  // Behavioural model state per instance.
  int m_act [2], m_load [2], m_acc [2], m_rel [2], m_err [2], m_done [2];
  logic [3:0] hist [2][8];
  logic [3:0] sp [2][4];

  // Hand-derived per-row expectations that pin the model.
  int lit_base [2][8]  = '{'{0, 1, 2, 3, 0, 0, 0, 0}, '{0, 2, 0, 0, 0, 0, 0, 0}};
  int lit_addr [2][8]  = '{'{0, 1, 2, 3, 0, 1, 0, 0}, '{0, 1, 2, 3, 0, 1, 2, 3}};
  int lit_first [2]    = '{3, 4};
  int base_log [2][8], addr_log [2][8], wr_n [2], rel_n [2], first_seen [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_load[d] = 0; m_acc[d] = 0; m_rel[d] = 0; m_err[d] = 0; m_done[d] = 0;
      wr_n[d] = 0; rel_n[d] = 0; first_seen[d] = 0;
    end
  end

  task automatic chk(input string nm, input int d, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0d want=%0d at %0t", nm, d, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ compare process
  always @(negedge clk) begin
    cyc++;
    if (cyc > 60000) begin
      $display("FAIL watchdog cycles got=%0d want<=60000", cyc);
      $fatal(1, "watchdog");
    end
    if (tmo != tmo_seen) begin
      chk("stimulus_timeout", 0, tmo, tmo_seen);
      tmo_seen = tmo;
    end
    for (int d = 0; d < 2; d++) begin
      int cnt, e_base, nd;
      bit e_rdy, e_wen, e_wv, rel_ev;
      cnt    = m_acc[d] - m_rel[d] * ST[d];
      e_rdy  = (m_load[d] != 0) && (cnt < SZ);
      e_wen  = e_rdy && in_valid[d];
      e_wv   = (m_act[d] != 0) && (cnt >= FS[d]) && (m_rel[d] < NW[d]);
      e_base = (m_rel[d] * ST[d]) % SZ;
      if (armed != 0) begin
        chk("in_ready", d, int'(in_ready[d]), int'(e_rdy));
        chk("ifmap_wen", d, int'(ifmap_wen[d]), int'(e_wen));
        if (e_wen) begin
          chk("w_addr", d, int'(ifmap_w_addr[d]), m_acc[d] % SZ);
          chk("din", d, int'(ifmap_din[d]), int'(in_data[d]));
        end
        chk("win_valid", d, int'(win_valid[d]), int'(e_wv));
        if (e_wv) begin
          chk("win_base", d, int'(win_base[d]), e_base);
          for (int k = 0; k < FS[d]; k++)
            chk("win_data", d, int'(sp[d][(e_base + k) % SZ]), int'(hist[d][m_rel[d] * ST[d] + k]));
          if (first_seen[d] == 0) begin
            first_seen[d] = 1;
            chk("first_win_writes", d, wr_n[d], lit_first[d]);
          end
        end
        chk("busy", d, int'(busy[d]), m_act[d]);
        chk("done", d, int'(done[d]), m_done[d]);
        chk("release_err", d, int'(release_err[d]), m_err[d]);
        if (m_done[d] != 0) begin
          chk("row_writes", d, wr_n[d], RL[d]);
          chk("row_releases", d, rel_n[d], NW[d]);
          for (int k = 0; k < NW[d]; k++) chk("row_base_seq", d, base_log[d][k], lit_base[d][k]);
          for (int k = 0; k < RL[d]; k++) chk("row_addr_seq", d, addr_log[d][k], lit_addr[d][k]);
          $display("row complete dut%0d writes=%0d releases=%0d", d, wr_n[d], rel_n[d]);
        end
      end
      // Log what the DUT actually did this cycle (lands on the coming edge).
      if (ifmap_wen[d]) begin
        sp[d][ifmap_w_addr[d]] = ifmap_din[d];
        if (wr_n[d] < 8) addr_log[d][wr_n[d]] = int'(ifmap_w_addr[d]);
        wr_n[d]++;
      end
      if (win_release[d] && win_valid[d]) begin
        if (rel_n[d] < 8) base_log[d][rel_n[d]] = int'(win_base[d]);
        rel_n[d]++;
        $display("window release dut%0d base=%0d", d, win_base[d]);
      end
      // Advance the model with this cycle's inputs.
      if (rst[d]) begin
        m_act[d] = 0; m_load[d] = 0; m_acc[d] = 0; m_rel[d] = 0; m_err[d] = 0; m_done[d] = 0;
        wr_n[d] = 0; rel_n[d] = 0; first_seen[d] = 0;
      end else begin
        rel_ev = win_release[d] && e_wv;
        nd = (rel_ev && (m_rel[d] + 1 == NW[d])) ? 1 : 0;
        if (win_release[d] && !e_wv) m_err[d] = 1;
        if ((m_act[d] == 0) && start[d]) begin
          m_act[d] = 1; m_load[d] = 1; m_acc[d] = 0; m_rel[d] = 0;
          wr_n[d] = 0; rel_n[d] = 0; first_seen[d] = 0;
        end else begin
          if (e_wen) begin
            if (m_acc[d] < 8) hist[d][m_acc[d]] = in_data[d];
            m_acc[d]++;
            if (m_acc[d] == RL[d]) m_load[d] = 0;
          end
          if (rel_ev) begin
            m_rel[d]++;
            if (m_rel[d] == NW[d]) m_act[d] = 0;
          end
        end
        m_done[d] = nd;
      end
    end
    if (rst[0] || rst[1]) armed = 1;
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in(input int d);
    start[d] = 1'b0; in_valid[d] = 1'b0; win_release[d] = 1'b0;
  endtask

  task automatic pulse_rst(input int d);
    clear_in(d);
    rst[d] = 1'b1;
    tick();
    rst[d] = 1'b0;
  endtask

  task automatic begin_row(input int d);
    clear_in(d);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
  endtask

  task automatic rand_step(input int d, input int pv, input int pr, input int pbad, input int pst);
    in_valid[d] = ($urandom_range(99) < pv);
    in_data[d]  = 4'($urandom);
    if (win_valid[d]) win_release[d] = ($urandom_range(99) < pr);
    else              win_release[d] = ($urandom_range(99) < pbad);
    start[d] = ($urandom_range(99) < pst);
    tick();
  endtask

  task automatic finish_row(input int d, input int pv, input int pr, input int pbad);
    int n = 0;
    while (!done[d] && n < 400) begin
      rand_step(d, pv, pr, pbad, 3);
      n++;
    end
    if (!done[d]) tmo++;
    clear_in(d);
  endtask

  initial begin
    int v, n;
    bit acc;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; in_data[d] = '0;
      clear_in(d);
    end
    tick(); tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick();

    // Full row, data 1..6, release as soon as a window is resident.
    begin_row(0);
    v = 1; n = 0;
    while (!done[0] && n < 100) begin
      in_data[0] = 4'(v);
      in_valid[0] = (v <= 6);
      win_release[0] = win_valid[0];
      acc = in_valid[0] && in_ready[0];
      tick();
      if (acc) v++;
      n++;
    end
    if (!done[0]) tmo++;
    clear_in(0);
    tick();

    // Backpressure, then a release in the same cycle an element is offered.
    begin_row(0);
    for (int i = 0; i < 7; i++) begin
      in_valid[0] = 1'b1; in_data[0] = 4'(i + 8);
      tick();
    end
    win_release[0] = 1'b1;
    tick();
    win_release[0] = 1'b0;
    tick();
    finish_row(0, 80, 50, 0);
    tick();

    // Spurious release with two resident elements; start during LOAD.
    begin_row(0);
    in_valid[0] = 1'b1; in_data[0] = 4'd3; tick();
    in_data[0] = 4'd5; tick();
    in_valid[0] = 1'b0; win_release[0] = 1'b1; start[0] = 1'b1; tick();
    win_release[0] = 1'b0; start[0] = 1'b0; tick();
    finish_row(0, 70, 50, 0);
    pulse_rst(0);

    // Reset in the middle of LOAD, then a fresh row.
    begin_row(0);
    in_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data[0] = 4'(i + 1);
      tick();
    end
    pulse_rst(0);
    tick();
    begin_row(0);
    finish_row(0, 100, 100, 0);
    tick();

    // STRIDE=2 instance: full-rate row, then random rows.
    begin_row(1);
    finish_row(1, 100, 100, 0);
    tick();
    for (int r = 0; r < 6; r++) begin
      begin_row(1);
      finish_row(1, 30 + int'($urandom_range(70)), 20 + int'($urandom_range(80)), 0);
      tick();
    end

    // Random rows on both instances, with spurious releases and aborts.
    for (int r = 0; r < 16; r++) begin
      int d;
      d = r % 2;
      begin_row(d);
      if ($urandom_range(3) == 0) begin
        repeat (1 + $urandom_range(9)) rand_step(d, 60, 50, 5, 5);
        pulse_rst(d);
      end else begin
        finish_row(d, 20 + int'($urandom_range(80)), 20 + int'($urandom_range(80)), 5);
        if ($urandom_range(1) == 1) pulse_rst(d);
      end
      tick();
    end

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
